// File: rtl/change_dispenser.sv
// change_dispenser: drains a credit into 2-unit then 1-unit coin ejects over req/ack.
// Define CHANGE_ABORT_EN to add the abort input and aborted status output.
module change_dispenser #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] amount,
   input  logic         coin_ack,
`ifdef CHANGE_ABORT_EN
   input  logic         abort,
   output logic         aborted,
`endif
   output logic         coin2,
   output logic         coin1,
   output logic         busy,
   output logic [N-1:0] remaining,
   output logic         done,
   output logic [N-1:0] coins_out
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      REL,
      DONE
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] rem_q, rem_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic         want2;

`ifdef CHANGE_ABORT_EN
   // An abort seen while the mechanism still holds ack is remembered here.
   logic         pend_q, pend_d;
   logic         aborted_q, aborted_d;
   logic         abort_hit;
`endif

   // State and datapath registers; reset drops any outstanding request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         cnt_q     <= '0;
`ifdef CHANGE_ABORT_EN
         pend_q    <= 1'b0;
         aborted_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
`ifdef CHANGE_ABORT_EN
         pend_q    <= pend_d;
         aborted_q <= aborted_d;
`endif
      end
   end

   // Next-state, datapath update and request decode.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      coin2   = 1'b0;
      coin1   = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      want2   = (rem_q >= N'(2));
`ifdef CHANGE_ABORT_EN
      pend_d    = pend_q;
      aborted_d = aborted_q;
      abort_hit = abort | pend_q;
`endif
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               rem_d   = amount;
               cnt_d   = '0;
               state_d = (amount != '0) ? REQ : DONE;
`ifdef CHANGE_ABORT_EN
               pend_d    = 1'b0;
               aborted_d = 1'b0;
`endif
            end
         end
         REQ: begin
            coin2 = want2;
            coin1 = (rem_q == N'(1));
            if (coin_ack) begin
               rem_d   = want2 ? rem_q - N'(2) : rem_q - N'(1);
               cnt_d   = cnt_q + N'(1);
               state_d = REL;
`ifdef CHANGE_ABORT_EN
               pend_d  = abort;
`endif
            end
`ifdef CHANGE_ABORT_EN
            else if (abort) begin
               state_d   = DONE;
               aborted_d = 1'b1;
            end
`endif
         end
         REL: begin
`ifdef CHANGE_ABORT_EN
            if (abort) pend_d = 1'b1;
            if (!coin_ack) begin
               if (abort_hit) begin
                  state_d   = DONE;
                  aborted_d = 1'b1;
               end else begin
                  state_d = (rem_q == '0) ? DONE : REQ;
               end
            end
`else
            if (!coin_ack) state_d = (rem_q == '0) ? DONE : REQ;
`endif
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
`ifdef CHANGE_ABORT_EN
            pend_d  = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign remaining = rem_q;
   assign coins_out = cnt_q;
`ifdef CHANGE_ABORT_EN
   assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed bench for change_dispenser.
// Abort scenario is compiled in when CHANGE_ABORT_EN is defined.
module tb_change_dispenser;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] amount;
   logic         coin_ack;
   logic         coin2, coin1, busy, done;
   logic [N-1:0] remaining, coins_out;
`ifdef CHANGE_ABORT_EN
   logic         abort;
   logic         aborted;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   change_dispenser #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .amount    (amount),
      .coin_ack  (coin_ack),
`ifdef CHANGE_ABORT_EN
      .abort     (abort),
      .aborted   (aborted),
`endif
      .coin2     (coin2),
      .coin1     (coin1),
      .busy      (busy),
      .remaining (remaining),
      .done      (done),
      .coins_out (coins_out)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; amount = '0; coin_ack = 1'b0;
`ifdef CHANGE_ABORT_EN
      abort = 1'b0;
`endif
      #1;
      checks++;
      if ({coin2, coin1, busy, done, remaining, coins_out} !== '0)
         $display("FAIL reset_outs got %b want 0",
                  {coin2, coin1, busy, done, remaining, coins_out});
      else passed++;
      step; step;
      reset = 1'b1;
      step;
      checks++;
      if ({busy, done} !== 2'b00)
         $display("FAIL reset_idle busy/done got %b want 00", {busy, done});
      else passed++;
   endtask

   task automatic test_five;
      logic [1:0]   exp_c [3] = '{2'b10, 2'b10, 2'b01};
      logic [N-1:0] exp_r [3] = '{4'd3, 4'd1, 4'd0};
      amount = 4'd5; start = 1'b1;
      step;
      start = 1'b0;
      checks++;
      if ({busy, remaining} !== {1'b1, 4'd5})
         $display("FAIL five_start busy/rem got %b/%0d want 1/5", busy, remaining);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({coin2, coin1} !== exp_c[k])
            $display("FAIL five_req%0d got %b want %b", k, {coin2, coin1}, exp_c[k]);
         else passed++;
         coin_ack = 1'b1;
         step;
         checks++;
         if ({coin2, coin1, remaining, coins_out} !== {2'b00, exp_r[k], 4'(k + 1)})
            $display("FAIL five_rel%0d got c=%b r=%0d n=%0d want c=00 r=%0d n=%0d",
                     k, {coin2, coin1}, remaining, coins_out, exp_r[k], k + 1);
         else passed++;
         coin_ack = 1'b0;
         step;
      end
      checks++;
      if ({done, busy, coin2, coin1} !== 4'b1100)
         $display("FAIL five_done got %b want 1100", {done, busy, coin2, coin1});
      else passed++;
      step;
      checks++;
      if ({done, busy, remaining, coins_out} !== {2'b00, 4'd0, 4'd3})
         $display("FAIL five_idle got d=%b b=%b r=%0d n=%0d want 0 0 0 3",
                  done, busy, remaining, coins_out);
      else passed++;
   endtask

   task automatic test_zero;
      amount = 4'd0; start = 1'b1;
      step;
      start = 1'b0;
      checks++;
      if ({done, busy, coin2, coin1, coins_out} !== {4'b1100, 4'd0})
         $display("FAIL zero_done got %b want 11000000",
                  {done, busy, coin2, coin1, coins_out});
      else passed++;
      step;
      checks++;
      if ({done, busy} !== 2'b00)
         $display("FAIL zero_idle got %b want 00", {done, busy});
      else passed++;
   endtask

   task automatic test_delay;
      amount = 4'd4; start = 1'b1;
      step;
      amount = 4'd7;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({coin2, coin1, remaining} !== {2'b10, 4'd4})
            $display("FAIL delay_hold%0d got c=%b r=%0d want c=10 r=4",
                     i, {coin2, coin1}, remaining);
         else passed++;
         step;
      end
      start = 1'b0;
      coin_ack = 1'b1;
      step;
      checks++;
      if ({remaining, coins_out} !== {4'd2, 4'd1})
         $display("FAIL delay_ack1 got r=%0d n=%0d want r=2 n=1", remaining, coins_out);
      else passed++;
      coin_ack = 1'b0;
      step;
      coin_ack = 1'b1;
      step;
      coin_ack = 1'b0;
      step;
      checks++;
      if ({done, remaining, coins_out} !== {1'b1, 4'd0, 4'd2})
         $display("FAIL delay_done got d=%b r=%0d n=%0d want 1 0 2",
                  done, remaining, coins_out);
      else passed++;
      step;
   endtask

   task automatic test_reset_mid;
      amount = 4'd3; start = 1'b1;
      step;
      start = 1'b0;
      checks++;
      if (coin2 !== 1'b1)
         $display("FAIL rmid_req coin2 got %b want 1", coin2);
      else passed++;
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({coin2, coin1, busy, done, remaining, coins_out} !== '0)
         $display("FAIL rmid_async got %b want 0",
                  {coin2, coin1, busy, done, remaining, coins_out});
      else passed++;
      step;
      reset = 1'b1;
      step;
      checks++;
      if (busy !== 1'b0)
         $display("FAIL rmid_idle busy got %b want 0", busy);
      else passed++;
      amount = 4'd1; start = 1'b1;
      step;
      start = 1'b0;
      checks++;
      if ({coin2, coin1} !== 2'b01)
         $display("FAIL rmid_coin1 got %b want 01", {coin2, coin1});
      else passed++;
      coin_ack = 1'b1;
      step;
      coin_ack = 1'b0;
      step;
      checks++;
      if ({done, remaining, coins_out} !== {1'b1, 4'd0, 4'd1})
         $display("FAIL rmid_done got d=%b r=%0d n=%0d want 1 0 1",
                  done, remaining, coins_out);
      else passed++;
      step;
   endtask

   task automatic test_ack_hold;
      amount = 4'd3; start = 1'b1;
      step;
      start = 1'b0;
      coin_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         checks++;
         if ({coin2, coin1, remaining, coins_out} !== {2'b00, 4'd1, 4'd1})
            $display("FAIL hold_rel%0d got c=%b r=%0d n=%0d want c=00 r=1 n=1",
                     i, {coin2, coin1}, remaining, coins_out);
         else passed++;
      end
      coin_ack = 1'b0;
      step;
      checks++;
      if ({coin2, coin1} !== 2'b01)
         $display("FAIL hold_req got %b want 01", {coin2, coin1});
      else passed++;
      coin_ack = 1'b1;
      step;
      coin_ack = 1'b0;
      step;
      checks++;
      if ({done, coins_out} !== {1'b1, 4'd2})
         $display("FAIL hold_done got d=%b n=%0d want 1 2", done, coins_out);
      else passed++;
      step;
   endtask

`ifdef CHANGE_ABORT_EN
   task automatic test_abort;
      amount = 4'd6; start = 1'b1;
      step;
      start = 1'b0;
      coin_ack = 1'b1;
      step;
      abort = 1'b1;
      step;
      abort = 1'b0;
      checks++;
      if ({done, coin2, coin1, remaining} !== {3'b000, 4'd4})
         $display("FAIL abort_defer got d=%b c=%b r=%0d want 0 00 4",
                  done, {coin2, coin1}, remaining);
      else passed++;
      coin_ack = 1'b0;
      step;
      checks++;
      if ({done, aborted, remaining, coins_out} !== {2'b11, 4'd4, 4'd1})
         $display("FAIL abort_done got d=%b a=%b r=%0d n=%0d want 1 1 4 1",
                  done, aborted, remaining, coins_out);
      else passed++;
      step;
      checks++;
      if ({busy, aborted} !== 2'b01)
         $display("FAIL abort_idle got b=%b a=%b want 0 1", busy, aborted);
      else passed++;
      amount = 4'd1; start = 1'b1;
      step;
      start = 1'b0;
      checks++;
      if ({aborted, coin1} !== 2'b01)
         $display("FAIL abort_clear got a=%b c1=%b want 0 1", aborted, coin1);
      else passed++;
      coin_ack = 1'b1;
      step;
      coin_ack = 1'b0;
      step;
      step;
   endtask
`endif

   initial begin
      test_reset;
      test_five;
      test_zero;
      test_delay;
      test_reset_mid;
      test_ack_hold;
`ifdef CHANGE_ABORT_EN
      test_abort;
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Drains a credit value into physical change by issuing coin-eject requests, 2-unit coins first and then 1-unit coins. It reads the credit count accumulated by the vending machine's up/down credit counter. It talks to the coin-eject mechanism over a four-phase req/ack handshake. It reports progress and signals completion to the vending controller FSM.

Parameters:
N, 4, width of credit amount and remaining count (same width as credit counter)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request to dispense; sampled only in IDLE
amount  input  N  credit to return; captured on accepted start
coin_ack  input  1  eject mechanism acknowledge (four-phase)
coin2  output  1  request eject of one 2-unit coin
coin1  output  1  request eject of one 1-unit coin
busy  output  1  high from accepted start until return to IDLE
remaining  output  N  credit not yet dispensed
done  output  1  one-cycle pulse when dispensing finishes
coins_out  output  N  number of coins issued in current/last transaction

Behaviour:
- States: IDLE, REQ, REL, DONE. Encoding is free; state register is async-reset to IDLE.
- Reset (reset=0, any time, including mid-transaction): state=IDLE; remaining=0, coins_out=0, busy=0, done=0, coin2=0, coin1=0. Outstanding requests are dropped immediately with no wait for ack.
- IDLE: busy=0. When start=1 at an edge:
  - remaining<=amount, coins_out<=0.
  - Next state is REQ if amount!=0, else DONE.
  - coin_ack is ignored in IDLE.
- REQ: busy=1. Outputs are combinational decodes of state and remaining:
  - coin2=(remaining>=2).
  - coin1=(remaining==1).
  - The request is held stable until coin_ack=1 is sampled.
  - On the edge where coin_ack=1: remaining decrements by 2 if coin2 was set, else by 1; coins_out increments by 1; state goes to REL.
- REL: coin2=coin1=0. Wait for coin_ack=0. At that edge, go to DONE if remaining==0, else REQ.
- DONE: done=1 and busy=1 for exactly one cycle, then unconditional return to IDLE. remaining and coins_out hold their values through IDLE until the next accepted start.
- start while busy (REQ/REL/DONE) is ignored; amount is not re-sampled.
- Latency:
  - start edge → coin request visible in the same cycle state=REQ (1 edge).
  - Each coin costs at least 2 edges (ack high, ack low).
  - amount=0 produces done 1 edge after start, with no coin requests.
- Arithmetic: remaining never underflows, because a 2-unit request is issued only when remaining>=2. coins_out wraps modulo 2^N; no saturation. The maximum count for amount=2^N-1 is 2^(N-1), which fits.
- coin2 and coin1 are never high simultaneously and never high outside REQ.

Optional Feature:
Macro CHANGE_ABORT_EN.
- Defined: adds input port abort (1 bit) and output port aborted (1 bit).
  - abort=1 in REQ with coin_ack=0: requests drop, remaining is unchanged, go to DONE.
  - abort=1 in REL: deferred until coin_ack returns low, then go to DONE regardless of remaining.
  - aborted is set on entry to DONE via abort and holds until the next accepted start. It clears on reset.
  - Abort in IDLE/DONE has no effect.
- Undefined: abort and aborted ports do not exist. Dispensing always runs to remaining==0.

Test Plan:
- amount=5, start, ack responder 1-cycle high/low → coin2, coin2, coin1 in order; remaining 5→3→1→0; coins_out=3; single done pulse; busy low after.
- amount=0, start → done one edge later; coin2/coin1 never asserted; coins_out=0.
- amount=4, ack delayed 6 cycles → coin2 stays high for all 6 cycles; remaining changes only on the ack edge; start pulses during busy with amount=7 are ignored.
- amount=3, reset=0 asserted while coin2 high (mid-REQ) → all outputs 0 immediately (asynchronously); after release, IDLE, and a new start with amount=1 gives a single coin1.
- ack held high 3 cycles in REL → no new request until ack falls; coin2 and coin1 never both high.
- CHANGE_ABORT_EN: amount=6, abort after first coin acked (in REL) → abort deferred to ack low, then DONE; remaining=4, coins_out=1, aborted=1; next start clears aborted.
